// File: rtl/fetch_buffer.sv
// Instruction-pair fetch queue between IF1 and decode: circular buffer of {pc, inst0, inst1}
// with almost-full back-pressure, flush, and combinational head read-out.
`ifndef INST_NOP
`define INST_NOP 32'h0340_0000
`endif
`ifndef PC_RESET
`define PC_RESET 32'h1C00_0000
`endif

module fetch_buffer #(
    parameter int DEPTH      = 8,
    parameter int ALMOST_GAP = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     fifo_valid,
    output logic                     fifo_ready,
    output logic                     fetch_buf_full,
    input  logic [31:0]              if1_fifo_pc,
    input  logic [31:0]              if1_fifo_inst0,
    input  logic [31:0]              if1_fifo_inst1,
    input  logic                     id_ready,
    output logic                     fbuf_valid,
    output logic [31:0]              fbuf_pc0,
    output logic [31:0]              fbuf_pc1,
    output logic [31:0]              fbuf_inst0,
    output logic [31:0]              fbuf_inst1,
    output logic [1:0]               fbuf_slot_valid,
    output logic [$clog2(DEPTH):0]   fbuf_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] ALMOST_CNT = CW'(DEPTH - ALMOST_GAP);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst0;
        logic [31:0] inst1;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;
    entry_t          head_entry;

    assign fifo_ready     = (count_q != FULL_CNT);
    assign fetch_buf_full = (count_q >= ALMOST_CNT);
    assign fbuf_valid     = (count_q != '0);
    assign fbuf_count     = count_q;

    // Readiness comes only from the registered count, so a full queue never
    // accepts a pair even when decode drains the head in the same cycle.
    assign push = fifo_valid && fifo_ready && !flush;
    assign pop  = fbuf_valid && id_ready && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + AW'(1);
            if (pop)  head_d = head_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is never cleared; the empty-state outputs below mask stale data.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[tail_q] <= '{pc: if1_fifo_pc, inst0: if1_fifo_inst0, inst1: if1_fifo_inst1};
        end
    end

    assign head_entry = mem[head_q];

    always_comb begin
        fbuf_pc0        = `PC_RESET;
        fbuf_pc1        = `PC_RESET + 32'd4;
        fbuf_inst0      = `INST_NOP;
        fbuf_inst1      = `INST_NOP;
        fbuf_slot_valid = 2'b00;
        if (fbuf_valid) begin
            fbuf_pc0        = head_entry.pc;
            fbuf_pc1        = head_entry.pc + 32'd4;
            fbuf_inst0      = head_entry.inst0;
            fbuf_inst1      = head_entry.inst1;
            // A pair starting at the upper word of an 8-byte block has no valid slot 1.
            fbuf_slot_valid = {~head_entry.pc[2], 1'b1};
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed and random checks of fetch_buffer against a queue reference model.
module tb_fetch_buffer;

    localparam logic [31:0] NOP  = 32'h0340_0000;
    localparam logic [31:0] PCR  = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        rst, flush, fifo_valid, id_ready;
    logic        fifo_ready, fetch_buf_full, fbuf_valid;
    logic [31:0] if1_fifo_pc, if1_fifo_inst0, if1_fifo_inst1;
    logic [31:0] fbuf_pc0, fbuf_pc1, fbuf_inst0, fbuf_inst1;
    logic [1:0]  fbuf_slot_valid;
    logic [3:0]  fbuf_count;

    int n_checks = 0;
    int n_pass   = 0;
    bit quiet    = 1'b0;
    logic [95:0] model_q[$];

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(8), .ALMOST_GAP(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fifo_valid(fifo_valid), .fifo_ready(fifo_ready), .fetch_buf_full(fetch_buf_full),
        .if1_fifo_pc(if1_fifo_pc), .if1_fifo_inst0(if1_fifo_inst0), .if1_fifo_inst1(if1_fifo_inst1),
        .id_ready(id_ready), .fbuf_valid(fbuf_valid),
        .fbuf_pc0(fbuf_pc0), .fbuf_pc1(fbuf_pc1), .fbuf_inst0(fbuf_inst0), .fbuf_inst1(fbuf_inst1),
        .fbuf_slot_valid(fbuf_slot_valid), .fbuf_count(fbuf_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One clock with the given inputs; the model follows the queue rules.
    task automatic drive(input logic v, input logic r, input logic f, input logic rs,
                         input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1);
        logic do_push, do_pop;
        fifo_valid = v; id_ready = r; flush = f; rst = rs;
        if1_fifo_pc = pc; if1_fifo_inst0 = i0; if1_fifo_inst1 = i1;
        do_push = v && (model_q.size() != 8) && !f;
        do_pop  = r && (model_q.size() != 0) && !f;
        @(posedge clk);
        #1;
        if (rs || f) model_q.delete();
        else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({pc, i0, i1});
        end
        if (!quiet)
            $display("cycle rst=%0b flush=%0b push=%0b pop=%0b pc=0x%08h count=%0d",
                     rs, f, do_push && !rs, do_pop && !rs, pc, model_q.size());
        fifo_valid = 1'b0; id_ready = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic check_state(input string tag);
        int cnt;
        logic [31:0] hpc;
        cnt = model_q.size();
        check({tag, ".count"}, 32'(fbuf_count), 32'(cnt));
        check({tag, ".valid"}, 32'(fbuf_valid), 32'(cnt != 0));
        check({tag, ".ready"}, 32'(fifo_ready), 32'(cnt != 8));
        check({tag, ".full"},  32'(fetch_buf_full), 32'(cnt >= 6));
        if (cnt != 0) begin
            hpc = model_q[0][95:64];
            check({tag, ".pc0"},   fbuf_pc0, hpc);
            check({tag, ".pc1"},   fbuf_pc1, hpc + 32'd4);
            check({tag, ".inst0"}, fbuf_inst0, model_q[0][63:32]);
            check({tag, ".inst1"}, fbuf_inst1, model_q[0][31:0]);
            check({tag, ".slot"},  32'(fbuf_slot_valid), hpc[2] ? 32'd1 : 32'd3);
        end else begin
            check({tag, ".pc0"},   fbuf_pc0, PCR);
            check({tag, ".pc1"},   fbuf_pc1, PCR + 32'd4);
            check({tag, ".inst0"}, fbuf_inst0, NOP);
            check({tag, ".inst1"}, fbuf_inst1, NOP);
            check({tag, ".slot"},  32'(fbuf_slot_valid), 32'd0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".valid"}, 32'(fbuf_valid), 32'd0);
        check({tag, ".ready"}, 32'(fifo_ready), 32'd1);
        check({tag, ".full"},  32'(fetch_buf_full), 32'd0);
        check({tag, ".count"}, 32'(fbuf_count), 32'd0);
        check({tag, ".slot"},  32'(fbuf_slot_valid), 32'd0);
        check({tag, ".inst0"}, fbuf_inst0, 32'h0340_0000);
        check({tag, ".inst1"}, fbuf_inst1, 32'h0340_0000);
        check({tag, ".pc0"},   fbuf_pc0, 32'h1C00_0000);
        check({tag, ".pc1"},   fbuf_pc1, 32'h1C00_0004);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; fifo_valid = 1'b0; id_ready = 1'b0;
        if1_fifo_pc = '0; if1_fifo_inst0 = '0; if1_fifo_inst1 = '0;

        // Reset
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        check_reset_values("reset");

        // Single push then pop; the push is not visible in its own cycle
        fifo_valid = 1'b1; if1_fifo_pc = 32'h1C00_0000;
        #1;
        check("single.lat0", 32'(fbuf_valid), 32'd0);
        drive(1, 0, 0, 0, 32'h1C00_0000, 32'h1111_1111, 32'h2222_2222);
        check("single.valid", 32'(fbuf_valid), 32'd1);
        check("single.pc0",   fbuf_pc0, 32'h1C00_0000);
        check("single.pc1",   fbuf_pc1, 32'h1C00_0004);
        check("single.slot",  32'(fbuf_slot_valid), 32'd3);
        check("single.inst0", fbuf_inst0, 32'h1111_1111);
        check("single.inst1", fbuf_inst1, 32'h2222_2222);
        drive(0, 1, 0, 0, 0, 0, 0);
        check("single.popped", 32'(fbuf_valid), 32'd0);

        // Fill to full, then a dropped ninth push
        for (int i = 0; i < 8; i++) begin
            check("fill.count", 32'(fbuf_count), 32'(i));
            check("fill.full",  32'(fetch_buf_full), 32'(i >= 6));
            drive(1, 0, 0, 0, 32'h1C00_0100 + 32'(i * 8), 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i));
        end
        check("fill.count8", 32'(fbuf_count), 32'd8);
        check("fill.ready8", 32'(fifo_ready), 32'd0);
        check("fill.full8",  32'(fetch_buf_full), 32'd1);
        drive(1, 0, 0, 0, 32'hDEAD_BEE0, 32'hDEAD_DEAD, 32'hDEAD_DEAD);
        check("fill.drop.count", 32'(fbuf_count), 32'd8);
        check("fill.drop.head",  fbuf_pc0, 32'h1C00_0100);

        // Concurrent push/pop across pointer wrap
        for (int i = 8; i < 28; i++) begin
            drive(1, 1, 0, 0, 32'h1C00_0100 + 32'(i * 8), 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i));
            check_state("wrap");
        end

        // Odd PC and 32-bit wrap of pc1
        drive(0, 0, 1, 0, 0, 0, 0);
        check_state("flush0");
        drive(1, 0, 0, 0, 32'h1C00_000C, 32'h3333_3333, 32'h4444_4444);
        check("odd.slot", 32'(fbuf_slot_valid), 32'd1);
        check("odd.pc1",  fbuf_pc1, 32'h1C00_0010);
        drive(1, 1, 0, 0, 32'hFFFF_FFFC, 32'h5555_5555, 32'h6666_6666);
        check("top.pc0",  fbuf_pc0, 32'hFFFF_FFFC);
        check("top.pc1",  fbuf_pc1, 32'h0000_0000);
        check("top.slot", 32'(fbuf_slot_valid), 32'd1);

        // Flush with push and pop at count 5
        for (int i = 0; i < 4; i++)
            drive(1, 0, 0, 0, 32'h1C00_0200 + 32'(i * 8), 32'(i), 32'(i));
        check("flushpp.pre", 32'(fbuf_count), 32'd5);
        drive(1, 1, 1, 0, 32'h1C00_0300, 32'h7777_7777, 32'h7777_7777);
        check_reset_values("flushpp");

        // Reset beats flush, push and pop at count 3
        for (int i = 0; i < 3; i++)
            drive(1, 0, 0, 0, 32'h1C00_0400 + 32'(i * 8), 32'(i), 32'(i));
        check("rstprio.pre", 32'(fbuf_count), 32'd3);
        drive(1, 1, 1, 1, 32'h1C00_0500, 32'h8888_8888, 32'h8888_8888);
        check_reset_values("rstprio");
        fifo_valid = 1'b1; id_ready = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        model_q.delete();
        check_reset_values("rstpp");
        rst = 1'b0; fifo_valid = 1'b0; id_ready = 1'b0;

        // Random stress against the reference queue
        quiet = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 5), ($urandom_range(0, 49) == 0), 1'b0,
                  {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom, $urandom);
            check_state("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
